// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - two-port round-robin shared radix-2 shift-add multiplier for RV32M ops
module mul_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [1:0]      req0_op_i,
  input  logic [XLEN-1:0] req0_a_i,
  input  logic [XLEN-1:0] req0_b_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [1:0]      req1_op_i,
  input  logic [XLEN-1:0] req1_a_i,
  input  logic [XLEN-1:0] req1_b_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic            resp_id_o,
  output logic [XLEN-1:0] resp_result_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state, state_next;
  logic              rr_ptr;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mcand;
  logic              id_q;
  logic [1:0]        op_q;
  logic              neg_flag;
  logic              resp_valid_q;
  logic              resp_id_q;
  logic [XLEN-1:0]   resp_result_q;

  logic              grant_id;
  logic              accept;
  logic [1:0]        sel_op;
  logic [XLEN-1:0]   sel_a, sel_b, mag_a, mag_b;
  logic              a_neg, b_neg;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] product_next;
  logic [2*XLEN-1:0] fixed;
  logic              calc_last;
  logic              resp_fire;

  // Arbitration; readies are also gated by reset so nothing is accepted while held in reset.
  always_comb begin
    grant_id     = (req0_valid_i & req1_valid_i) ? rr_ptr : req1_valid_i;
    accept       = (state == S_IDLE) & rst_i & ~flush_i & (req0_valid_i | req1_valid_i);
    req0_ready_o = accept & ~grant_id;
    req1_ready_o = accept & grant_id;
  end

  always_comb begin
    sel_op = grant_id ? req1_op_i : req0_op_i;
    sel_a  = grant_id ? req1_a_i  : req0_a_i;
    sel_b  = grant_id ? req1_b_i  : req0_b_i;
    a_neg  = ((sel_op == OP_MULH) | (sel_op == OP_MULHSU)) & sel_a[XLEN-1];
    b_neg  = (sel_op == OP_MULH) & sel_b[XLEN-1];
    mag_a  = a_neg ? -sel_a : sel_a;
    mag_b  = b_neg ? -sel_b : sel_b;
  end

  // Carry out of the add lands in the top bit, which the right shift brings back into range.
  always_comb begin
    sum          = product[0] ? ({1'b0, product[2*XLEN-1:XLEN]} + {1'b0, mcand})
                              : {1'b0, product[2*XLEN-1:XLEN]};
    product_next = {sum, product[XLEN-1:1]};
    fixed        = neg_flag ? -product : product;
    calc_last    = (count == CW'(XLEN-1));
    resp_fire    = resp_valid_q & resp_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_o     = (state != S_IDLE);
    unique case (state)
      S_IDLE: if (accept) state_next = S_CALC;
      S_CALC: begin
        if (flush_i)        state_next = S_IDLE;
        else if (calc_last) state_next = S_FIX;
      end
      S_FIX:  state_next = flush_i ? S_IDLE : S_DONE;
      S_DONE: if (flush_i | resp_fire) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rr_ptr        <= 1'b0;
      count         <= '0;
      product       <= '0;
      mcand         <= '0;
      id_q          <= 1'b0;
      op_q          <= OP_MUL;
      neg_flag      <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            id_q     <= grant_id;
            op_q     <= sel_op;
            mcand    <= mag_a;
            product  <= {{XLEN{1'b0}}, mag_b};
            count    <= '0;
            neg_flag <= a_neg ^ b_neg;
            rr_ptr   <= ~grant_id;
          end
        end
        S_CALC: begin
          if (!flush_i) begin
            product <= product_next;
            count   <= count + CW'(1);
          end
        end
        S_FIX: begin
          if (!flush_i) begin
            product       <= fixed;
            resp_result_q <= (op_q == OP_MUL) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
            resp_id_q     <= id_q;
            resp_valid_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (flush_i | resp_fire) resp_valid_q <= 1'b0;
        end
        default: resp_valid_q <= 1'b0;
      endcase
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign resp_id_o     = resp_id_q;
  assign resp_result_o = resp_result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed table-driven bench for mul_sequencer
module tb_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, busy;
  logic [31:0] resp_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  mul_sequencer #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
    .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
    .req1_a_i(req1_a), .req1_b_i(req1_b),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
    .resp_result_o(resp_result), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic port, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string name);
    int n;
    @(negedge clk);
    if (port) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check({name, " accept"}, 64'(port ? req1_ready : req0_ready), 64'd1);
    @(posedge clk); #1;
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Entered just after the accept edge; returns at a negedge. lat counts edges, accept edge = 1.
  task automatic wait_resp(output int lat);
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 60) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  task automatic take(input logic id, input logic [31:0] res, input string name);
    check({name, " valid"}, 64'(resp_valid), 64'd1);
    check({name, " id"}, 64'(resp_id), 64'(id));
    check({name, " result"}, 64'(resp_result), 64'(res));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    int  lat;
    int  n;
    logic g;
    logic bad;
    logic [31:0] exp_by_port[2];

    vecs[0]  = '{1'b0, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{1'b0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[2]  = '{1'b1, 2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[3]  = '{1'b1, 2'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    vecs[4]  = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5]  = '{1'b1, 2'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[6]  = '{1'b0, 2'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    vecs[7]  = '{1'b0, 2'd2, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
    vecs[8]  = '{1'b1, 2'd3, 32'h80000000, 32'h00000002, 32'h00000001};
    vecs[9]  = '{1'b0, 2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[10] = '{1'b1, 2'd2, 32'h00000005, 32'hFFFFFFFF, 32'h00000004};
    vecs[11] = '{1'b0, 2'd1, 32'h00000000, 32'h80000000, 32'h00000000};

    rst = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = 2'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 2'd0; req1_a = '0; req1_b = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset resp_id", 64'(resp_id), 64'd0);
    check("reset resp_result", 64'(resp_result), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    check("reset readies", {62'd0, req1_ready, req0_ready}, 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;

    // Both ports requesting continuously from reset: grants alternate starting at port 0.
    @(negedge clk);
    req0_op = 2'd3; req0_a = 32'hFFFFFFFF; req0_b = 32'hFFFFFFFF; exp_by_port[0] = 32'hFFFFFFFE;
    req1_op = 2'd0; req1_a = 32'h00000007; req1_b = 32'hFFFFFFFD; exp_by_port[1] = 32'hFFFFFFEB;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready | req1_ready) && n < 50) begin
        @(negedge clk); #1; n++;
      end
      check("rr ready seen", 64'(req0_ready | req1_ready), 64'd1);
      check("rr one-hot", 64'(req0_ready & req1_ready), 64'd0);
      g = req1_ready;
      check("rr grant order", 64'(g), 64'(k % 2));
      @(posedge clk); #1;
      wait_resp(lat);
      check("rr busy readies", {62'd0, req1_ready, req0_ready}, 64'd0);
      take(g, exp_by_port[g], "rr resp");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      wait_resp(lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd34);
      take(vecs[i].port, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure: response held for 10 cycles, no new accept until after the handshake.
    issue(1'b1, 2'd2, 32'h00000005, 32'hFFFFFFFF, "bp");
    wait_resp(lat);
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 32'h00000007; req0_b = 32'hFFFFFFFD;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!resp_valid || resp_id !== 1'b1 || resp_result !== 32'h00000004 || req0_ready || req1_ready)
        bad = 1'b1;
      @(negedge clk);
    end
    check("bp stable hold", 64'(bad), 64'd0);
    resp_ready = 1'b1; #1;
    check("bp no ready in handshake cycle", 64'(req0_ready), 64'd0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp valid dropped", 64'(resp_valid), 64'd0);
    check("bp ready next cycle", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_resp(lat);
    take(1'b0, 32'hFFFFFFEB, "bp follow");

    // Flush during CALC cycle 5.
    issue(1'b0, 2'd3, 32'h12345678, 32'h9ABCDEF0, "flc");
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flc busy", 64'(busy), 64'd0);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) bad = 1'b1;
    end
    check("flc no response", 64'(bad), 64'd0);
    issue(1'b0, 2'd3, 32'h12345678, 32'h9ABCDEF0, "flc2");
    wait_resp(lat);
    take(1'b0, 32'h0B00EA4E, "flc2");

    // Flush on first DONE cycle.
    issue(1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "fld");
    wait_resp(lat);
    check("fld reached done", 64'(resp_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fld valid dropped", 64'(resp_valid), 64'd0);
    check("fld busy", 64'(busy), 64'd0);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 32'd1; req0_b = 32'd1;
    flush = 1'b1; #1;
    check("idle flush ready", 64'(req0_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; req0_valid = 1'b0;
    check("idle flush busy", 64'(busy), 64'd0);
    issue(1'b0, 2'd3, 32'h12345678, 32'h9ABCDEF0, "fld2");
    wait_resp(lat);
    take(1'b0, 32'h0B00EA4E, "fld2");

    // Reset mid-CALC after a port 0 grant (rr_ptr=1 before reset).
    issue(1'b0, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "rst");
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst resp_valid", 64'(resp_valid), 64'd0);
    check("midrst resp_id", 64'(resp_id), 64'd0);
    check("midrst resp_result", 64'(resp_result), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst readies", {62'd0, req1_ready, req0_ready}, 64'd0);
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 32'hFFFFFFFF; req0_b = 32'hFFFFFFFF;
    req1_valid = 1'b1; req1_op = 2'd3; req1_a = 32'h80000000; req1_b = 32'h00000002;
    #1;
    check("midrst port0 first", {62'd0, req1_ready, req0_ready}, 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(lat);
    take(1'b0, 32'h00000001, "midrst resp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Shares one iterative shift-add multiply datapath between two requesters: port 0 (core EX stage) and port 1 (a coprocessor/accelerator port).
- Arbitrates round-robin, latches operands and sequences the radix-2 iteration.
- Handles RV32M sign modes (MUL/MULH/MULHSU/MULHU) by magnitude conversion and final negation.
- Returns the result over a valid/ready response channel tagged with the requester id.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-low. Registers reset when rst_i=0 at a rising edge.
- flush_i  input  1  abort the in-flight operation and discard any pending response.
- req0_valid_i  input  1  port 0 request valid.
- req0_ready_o  output  1  port 0 request accepted this cycle.
- req0_op_i  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- req0_a_i  input  XLEN  multiplicand (rs1).
- req0_b_i  input  XLEN  multiplier (rs2).
- req1_valid_i, req1_ready_o, req1_op_i, req1_a_i, req1_b_i  same as port 0, for port 1.
- resp_valid_o  output  1  result valid.
- resp_ready_i  input  1  consumer accepts result.
- resp_id_o  output  1  requester that issued the result (0/1).
- resp_result_o  output  XLEN  result word.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_i=0 at edge):
  - state=IDLE, rr_ptr=0, iteration count=0, product register=0.
  - resp_valid_o=0, resp_id_o=0, resp_result_o=0, busy_o=0, both ready outputs 0.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE arbitration (combinational):
  - If only one valid is high, that port is granted.
  - If both are high, grant rr_ptr.
  - reqN_ready_o = (state==IDLE) & reqN_valid_i & grant==N. Never both high.
  - No ready outside IDLE. Requesters hold valid and operands stable until ready.
- Accept edge:
  - Latch id and op.
  - Latch |a| if a is signed and negative, else a; same for b.
  - neg_flag = sign(a)^sign(b), counting only the operands that are signed for the op. MUL counts neither.
  - product = {XLEN zeros, |b|}, count=0, rr_ptr = ~granted id, go to CALC.
- CALC, one bit per cycle for exactly XLEN cycles:
  - If product[0]=1, add |a| to the upper half using an XLEN+1-bit sum so the carry is kept.
  - Then shift the whole 2*XLEN+1-bit value right by 1. count++.
  - At count==XLEN-1, go to FIX.
- FIX, 1 cycle, always present so latency is fixed:
  - If neg_flag, product = two's complement over 2*XLEN bits.
  - resp_result_o = low XLEN bits for MUL, high XLEN bits otherwise.
  - resp_id_o = latched id. Go to DONE with resp_valid_o=1.
- Latency: accept edge E -> resp_valid_o high in the cycle after edge E+XLEN+1, i.e. XLEN+2 cycles (34 at default).
- DONE:
  - Hold resp_valid_o, resp_id_o and resp_result_o stable until resp_valid_o & resp_ready_i.
  - Then resp_valid_o=0 and return to IDLE.
  - A new request can be accepted in the cycle after the response handshake edge, not in the same cycle.
- flush_i=1 at an edge in CALC/FIX/DONE:
  - Return to IDLE, resp_valid_o=0, no response is ever produced.
  - rr_ptr is not restored.
- flush_i=1 in IDLE: no request is accepted that cycle (ready forced 0).
- Reset during CALC/DONE: immediate return to reset values; the operation is lost.
- Overflow: MUL keeps only the low word (wraps). A signed -2^31 operand has magnitude 2^31, which fits unsigned XLEN.

Test Plan:
1. Port 0 MULHU, a=0xFFFFFFFF, b=0xFFFFFFFF -> resp 0xFFFFFFFE, id=0, resp_valid_o rises exactly 34 cycles after the accept edge. MUL with the same operands -> 0x00000001.
2. Port 1 MULH, a=0x80000000, b=0x80000000 -> 0x40000000. MULH a=0xFFFFFFFE(-2), b=3 -> 0xFFFFFFFF. MULHSU a=0xFFFFFFFF(-1), b=0xFFFFFFFF -> 0xFFFFFFFF. MUL a=7, b=0xFFFFFFFD(-3) -> 0xFFFFFFEB.
3. Both valid every cycle from reset -> grants alternate 0,1,0,1 with ids matching; the requester not granted holds valid, ready stays 0, and no request is lost.
4. Result ready, resp_ready_i held 0 for 10 cycles -> valid/id/result stable for all 10 cycles; both ready outputs stay 0. After the response handshake, ready returns in the following cycle.
5. flush_i pulsed on CALC cycle 5, and separately on the first DONE cycle -> immediate IDLE, no resp_valid_o, and the next request completes correctly: MULHU 0x12345678*0x9ABCDEF0 high = 0x0B00EA4E.
6. rst_i=0 for one edge mid-CALC -> all outputs 0 next cycle, rr_ptr=0; with both ports valid afterwards, port 0 is granted first.
